rs_flag_arbiter: RTL and testbench

//   Shares a bank of NFLAG set/reset flags (RS flip-flop semantics, set-dominant)

---
 rtl/rs_flag_arbiter.sv | 119 +++++++++++
 tb/tb_rs_flag_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_flag_arbiter.sv
// Round-robin arbiter giving NREQ requesters access to a bank of set-dominant RS flags.
// Each transaction runs IDLE -> APPLY -> ACK and is acked with the flag's prior value.
module rs_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 rdata,
    output logic [NFLAG-1:0]     q,
    output logic [NFLAG-1:0]     qbar,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    // Handshake: a requester holds req until its ack; gnt stays high from the
    // grant edge through the single ack cycle, and op/idx are frozen at grant.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_r;
    logic            any_req;
    logic [1:0]      op_r;
    logic [IDXW-1:0] idx_r;
    logic [NREQ-1:0] gnt_r;
    logic            idx_ok;

    // First active request at or after rr_ptr, wrapping around.
    always_comb begin
        win     = rr_ptr;
        any_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req[(int'(rr_ptr) + i) % NREQ]) begin
                win     = PW'((int'(rr_ptr) + i) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = APPLY;
            APPLY:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign idx_ok = (int'(idx_r) < NFLAG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= '0;
            win_r  <= '0;
            op_r   <= '0;
            idx_r  <= '0;
            rr_ptr <= '0;
            rdata  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_r <= win;
                        gnt_r <= NREQ'(1) << win;
                        op_r  <= req_op[2*win +: 2];
                        idx_r <= req_idx[IDXW*win +: IDXW];
                    end
                end
                APPLY: rdata <= idx_ok ? q[idx_r] : 1'b0;
                ACK: begin
                    gnt_r  <= '0;
                    rr_ptr <= (win_r == PW'(NREQ - 1)) ? '0 : win_r + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // clr_all wins over the APPLY update; op 11 behaves as set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr_all) begin
            q <= '0;
        end else if (state == APPLY && idx_ok) begin
            case (op_r)
                2'b01, 2'b11: q[idx_r] <= 1'b1;
                2'b10:        q[idx_r] <= 1'b0;
                default:      ;
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign ack  = (state == ACK) ? gnt_r : '0;
    assign busy = (state != IDLE);
    assign qbar = ~q;

endmodule

// File: tb/tb_rs_flag_arbiter.sv
// Bench for rs_flag_arbiter: directed scenarios plus randomized transactions
// checked against a flag-array / pointer reference model.
module tb_rs_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [IDXW*NREQ-1:0] req_idx = '0;
    logic                 clr_all = 1'b0;
    logic [NREQ-1:0]      gnt, ack;
    logic                 rdata, busy;
    logic [NFLAG-1:0]     q, qbar;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit              m_q[NFLAG];
    int              m_ptr;
    int              exp_w;
    logic            exp_rd;
    logic [NREQ-1:0] exp_g;

    // observations from one transaction
    logic [NREQ-1:0]  o_g1, o_a1, o_g2, o_a2, o_g3, o_a3;
    logic             o_b1, o_b3, o_rd;
    logic [NFLAG-1:0] o_q2, o_qb2;

    always #5 clk = ~clk;

    rs_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_idx(req_idx),
        .clr_all(clr_all), .gnt(gnt), .ack(ack), .rdata(rdata), .q(q), .qbar(qbar),
        .busy(busy)
    );

    function automatic logic [NFLAG-1:0] model_vec();
        logic [NFLAG-1:0] v;
        for (int i = 0; i < NFLAG; i++) v[i] = m_q[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NFLAG; i++) m_q[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_txn(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] ops,
                             input logic [IDXW*NREQ-1:0] idxs, input bit clr);
        int op, fi;
        exp_w = -1;
        for (int k = 0; k < NREQ; k++)
            if (exp_w < 0 && r[(m_ptr + k) % NREQ]) exp_w = (m_ptr + k) % NREQ;
        op     = int'(ops[2*exp_w +: 2]);
        fi     = int'(idxs[IDXW*exp_w +: IDXW]);
        exp_rd = (fi < NFLAG) ? logic'(m_q[fi]) : 1'b0;
        if (fi < NFLAG && op != 0) m_q[fi] = (op != 2);
        if (clr) for (int i = 0; i < NFLAG; i++) m_q[i] = 1'b0;
        m_ptr = (exp_w + 1) % NREQ;
        exp_g = NREQ'(1) << exp_w;
    endtask

    // Runs one 3-cycle transaction starting from IDLE at a negedge; ends at a negedge in IDLE.
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] ops,
                          input logic [IDXW*NREQ-1:0] idxs, input bit clr, input bit mutate);
        req = r; req_op = ops; req_idx = idxs; clr_all = 1'b0;
        @(posedge clk); @(negedge clk);
        o_g1 = gnt; o_a1 = ack; o_b1 = busy;
        clr_all = clr;
        if (mutate) begin
            req     = r & NREQ'($urandom);
            req_op  = (2*NREQ)'($urandom);
            req_idx = (IDXW*NREQ)'($urandom);
        end
        @(posedge clk); @(negedge clk);
        o_g2 = gnt; o_a2 = ack; o_rd = rdata; o_q2 = q; o_qb2 = qbar;
        clr_all = 1'b0;
        if (mutate) req = NREQ'($urandom);
        @(posedge clk); @(negedge clk);
        o_g3 = gnt; o_a3 = ack; o_b3 = busy;
        req = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
        n_checks++; if (qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar: got %h want ff", qbar); end
        n_checks++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_ack: got %b/%b want 0000/0000", gnt, ack); end
        n_checks++; if (busy !== 1'b0 || rdata !== 1'b0) begin n_fail++; $display("FAIL reset_busy_rdata: got %b/%b want 0/0", busy, rdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_set();
        model_txn(4'b0100, 8'b00_01_00_00, 12'b000_101_000_000, 1'b0);
        do_txn(4'b0100, 8'b00_01_00_00, 12'b000_101_000_000, 1'b0, 1'b0);
        n_checks++; if (o_g1 !== 4'b0100 || o_a1 !== 4'b0000) begin n_fail++; $display("FAIL single_grant: gnt=%b ack=%b want 0100/0000", o_g1, o_a1); end
        n_checks++; if (o_a2 !== 4'b0100 || o_g2 !== 4'b0100) begin n_fail++; $display("FAIL single_ack: ack=%b gnt=%b want 0100/0100", o_a2, o_g2); end
        n_checks++; if (o_q2 !== 8'h20 || o_rd !== 1'b0) begin n_fail++; $display("FAIL single_q: q=%h rdata=%b want 20/0", o_q2, o_rd); end
        n_checks++; if (o_qb2 !== 8'hDF) begin n_fail++; $display("FAIL single_qbar: got %h want df", o_qb2); end
        n_checks++; if (o_g3 !== 4'b0000 || o_a3 !== 4'b0000 || o_b3 !== 1'b0) begin n_fail++; $display("FAIL single_done: gnt=%b ack=%b busy=%b want 0000/0000/0", o_g3, o_a3, o_b3); end
    endtask

    task automatic test_round_robin();
        logic [IDXW*NREQ-1:0] idxs;
        for (int t = 0; t < 5; t++) begin
            idxs = (IDXW*NREQ)'($urandom);
            model_txn(4'b1111, '0, idxs, 1'b0);
            do_txn(4'b1111, '0, idxs, 1'b0, 1'b0);
            n_checks++; if (o_g1 !== exp_g || o_a1 !== 4'b0000) begin n_fail++; $display("FAIL rr_grant[%0d]: gnt=%b ack=%b want %b/0000", t, o_g1, o_a1, exp_g); end
            n_checks++; if (o_a2 !== exp_g || o_rd !== exp_rd) begin n_fail++; $display("FAIL rr_ack[%0d]: ack=%b rdata=%b want %b/%b", t, o_a2, o_rd, exp_g, exp_rd); end
            n_checks++; if (o_g3 !== 4'b0000 || o_a3 !== 4'b0000) begin n_fail++; $display("FAIL rr_idle[%0d]: gnt=%b ack=%b want 0000/0000", t, o_g3, o_a3); end
        end
    endtask

    task automatic test_set_dominance();
        logic [1:0] op_list[3] = '{2'b11, 2'b10, 2'b00};
        logic       rd_list[3] = '{1'b0, 1'b1, 1'b0};
        logic       q3_list[3] = '{1'b1, 1'b0, 1'b0};
        logic [2*NREQ-1:0] ops;
        for (int t = 0; t < 3; t++) begin
            ops = '0; ops[3:2] = op_list[t];
            model_txn(4'b0010, ops, 12'b000_000_011_000, 1'b0);
            do_txn(4'b0010, ops, 12'b000_000_011_000, 1'b0, 1'b0);
            n_checks++; if (o_q2[3] !== q3_list[t] || o_q2 !== model_vec()) begin n_fail++; $display("FAIL dom_q[%0d]: got %h want q[3]=%b q=%h", t, o_q2, q3_list[t], model_vec()); end
            n_checks++; if (o_rd !== rd_list[t] || o_a2 !== 4'b0010) begin n_fail++; $display("FAIL dom_rd[%0d]: rdata=%b ack=%b want %b/0010", t, o_rd, o_a2, rd_list[t]); end
        end
    endtask

    task automatic test_clr_all();
        logic [IDXW*NREQ-1:0] idxs;
        for (int f = 4; f < 8; f++) begin
            idxs = '0; idxs[2:0] = IDXW'(f);
            model_txn(4'b0001, 8'b00_00_00_01, idxs, 1'b0);
            do_txn(4'b0001, 8'b00_00_00_01, idxs, 1'b0, 1'b0);
        end
        n_checks++; if (q !== 8'hF0) begin n_fail++; $display("FAIL clr_setup: q=%h want f0", q); end
        model_txn(4'b0001, 8'b00_00_00_01, 12'b000_000_000_001, 1'b1);
        do_txn(4'b0001, 8'b00_00_00_01, 12'b000_000_000_001, 1'b1, 1'b0);
        n_checks++; if (o_q2 !== 8'h00 || o_qb2 !== 8'hFF) begin n_fail++; $display("FAIL clr_vs_set_q: q=%h qbar=%h want 00/ff", o_q2, o_qb2); end
        n_checks++; if (o_rd !== 1'b0 || o_a2 !== 4'b0001) begin n_fail++; $display("FAIL clr_vs_set_ack: rdata=%b ack=%b want 0/0001", o_rd, o_a2); end
        model_txn(4'b0001, 8'b00_00_00_01, 12'b000_000_000_010, 1'b0);
        do_txn(4'b0001, 8'b00_00_00_01, 12'b000_000_000_010, 1'b0, 1'b0);
        clr_all = 1'b1;
        for (int i = 0; i < NFLAG; i++) m_q[i] = 1'b0;
        @(posedge clk); @(negedge clk);
        clr_all = 1'b0;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle: q=%h busy=%b want 00/0", q, busy); end
    endtask

    task automatic test_abort();
        model_txn(4'b0100, 8'b00_01_00_00, 12'b000_110_000_000, 1'b0);
        do_txn(4'b0100, 8'b00_01_00_00, 12'b000_110_000_000, 1'b0, 1'b0);
        n_checks++; if (q !== 8'h40) begin n_fail++; $display("FAIL abort_setup: q=%h want 40", q); end
        req = 4'b1000; req_op = 8'b01_00_00_00; req_idx = 12'b111_000_000_000;
        @(posedge clk); @(negedge clk);
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_grant: gnt=%b want 1000", gnt); end
        rst_n = 1'b0; req = '0;
        model_reset();
        #1;
        n_checks++; if (q !== 8'h00 || qbar !== 8'hFF) begin n_fail++; $display("FAIL abort_q: q=%h qbar=%h want 00/ff", q, qbar); end
        n_checks++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_ctl: gnt=%b ack=%b busy=%b want 0000/0000/0", gnt, ack, busy); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++; if (ack !== 4'b0000 || q !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet[%0d]: ack=%b q=%h busy=%b want 0000/00/0", c, ack, q, busy); end
        end
        model_txn(4'b1001, '0, '0, 1'b0);
        do_txn(4'b1001, '0, '0, 1'b0, 1'b0);
        n_checks++; if (o_g1 !== 4'b0001 || o_g1 !== exp_g) begin n_fail++; $display("FAIL abort_ptr: gnt=%b want 0001", o_g1); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0]      r;
        logic [2*NREQ-1:0]    ops;
        logic [IDXW*NREQ-1:0] idxs;
        bit                   clr;
        for (int t = 0; t < 40; t++) begin
            r    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ops  = (2*NREQ)'($urandom);
            idxs = (IDXW*NREQ)'($urandom);
            clr  = ($urandom_range(0, 7) == 0);
            model_txn(r, ops, idxs, clr);
            do_txn(r, ops, idxs, clr, 1'b1);
            n_checks++; if (o_g1 !== exp_g || o_a1 !== 4'b0000 || o_b1 !== 1'b1) begin n_fail++; $display("FAIL rnd_grant[%0d]: gnt=%b ack=%b busy=%b want %b/0000/1", t, o_g1, o_a1, o_b1, exp_g); end
            n_checks++; if (o_a2 !== exp_g || o_g2 !== exp_g || o_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_ack[%0d]: ack=%b gnt=%b rdata=%b want %b/%b/%b", t, o_a2, o_g2, o_rd, exp_g, exp_g, exp_rd); end
            n_checks++; if (o_q2 !== model_vec() || o_qb2 !== ~model_vec()) begin n_fail++; $display("FAIL rnd_q[%0d]: q=%h qbar=%h want %h/%h", t, o_q2, o_qb2, model_vec(), ~model_vec()); end
            n_checks++; if (o_g3 !== 4'b0000 || o_a3 !== 4'b0000 || o_b3 !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d]: gnt=%b ack=%b busy=%b want 0000/0000/0", t, o_g3, o_a3, o_b3); end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_round_robin();
        test_set_dominance();
        test_clr_all();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
